reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 23 ++
 rtl/reset_seq_counter.sv | 40 ++++
 rtl/reset_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared state type, default configuration and sizing helper for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } seqState_e;

  localparam int DefNumOuts   = 3;
  localparam int DefHoldCycles = 16;
  localparam int DefStageGap  = 4;
  localparam int DefAckTimeout = 32;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_seq_counter.sv
// Loadable down-counter with zero/one flags; saturates at zero instead of wrapping.
module reset_seq_counter #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] loadVal_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = loadVal_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign one_o  = (count_q == W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with per-domain acknowledge and software restart.
// Define RESET_SEQUENCER_TIMEOUT_EN to enable the acknowledge timeout and retry.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_OUTS    = DefNumOuts,
  parameter int HOLD_CYCLES = DefHoldCycles,
  parameter int STAGE_GAP   = DefStageGap,
  parameter int ACK_TIMEOUT = DefAckTimeout
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_rst_req_i,
  input  logic [NUM_OUTS-1:0] stage_ack_i,
  output logic [NUM_OUTS-1:0] rst_o,
  output logic [2:0]          stage_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o
);

  localparam int CntW = $clog2(maxOf3(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT) + 1);

  seqState_e           state_q, state_d;
  logic [2:0]          stage_q, stage_d;
  logic [NUM_OUTS-1:0] rstVec_q, rstVec_d;

  logic            cntClear;
  logic            cntLoad;
  logic [CntW-1:0] cntLoadVal;
  logic            cntDec;
  logic            cntZero;
  logic            cntOne;

  logic ackCur;
  logic lastStage;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic timeout_q, timeout_d;
`endif

  reset_seq_counter #(
    .W(CntW)
  ) uCounter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cntClear),
    .load_i    (cntLoad),
    .loadVal_i (cntLoadVal),
    .dec_i     (cntDec),
    .zero_o    (cntZero),
    .one_o     (cntOne)
  );

  always_comb begin
    ackCur = 1'b0;
    for (int k = 0; k < NUM_OUTS; k++) begin
      if (3'(k) == stage_q) begin
        ackCur = stage_ack_i[k];
      end
    end
  end

  assign lastStage = (stage_q == 3'(NUM_OUTS - 1));

  // HOLD starts from a cleared counter, so its first edge loads the remaining
  // count; the release edge itself completes the gap, hence the minus-one loads.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    rstVec_d   = rstVec_q;
    cntClear   = 1'b0;
    cntLoad    = 1'b0;
    cntLoadVal = '0;
    cntDec     = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif

    if (sw_rst_req_i) begin
      state_d  = ST_HOLD;
      stage_d  = '0;
      rstVec_d = '1;
      cntClear = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cntOne || (cntZero && (HOLD_CYCLES == 1))) begin
            state_d  = ST_RELEASE;
            cntClear = 1'b1;
          end else if (cntZero) begin
            cntLoad    = 1'b1;
            cntLoadVal = CntW'(HOLD_CYCLES - 1);
          end else begin
            cntDec = 1'b1;
          end
        end

        ST_RELEASE: begin
          for (int k = 0; k < NUM_OUTS; k++) begin
            if (3'(k) == stage_q) begin
              rstVec_d[k] = 1'b0;
            end
          end
          state_d = ST_WAIT_ACK;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          cntLoad    = 1'b1;
          cntLoadVal = CntW'(ACK_TIMEOUT);
`endif
        end

        ST_WAIT_ACK: begin
          if (ackCur) begin
            cntClear = 1'b1;
            if (lastStage) begin
              state_d = ST_DONE;
            end else if (STAGE_GAP == 1) begin
              state_d = ST_RELEASE;
              stage_d = stage_q + 3'd1;
            end else begin
              state_d    = ST_GAP;
              cntClear   = 1'b0;
              cntLoad    = 1'b1;
              cntLoadVal = CntW'(STAGE_GAP - 1);
            end
          end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          else if (cntOne) begin
            timeout_d = 1'b1;
            state_d   = ST_HOLD;
            stage_d   = '0;
            rstVec_d  = '1;
            cntClear  = 1'b1;
          end else begin
            cntDec = 1'b1;
          end
`endif
        end

        ST_GAP: begin
          if (cntOne) begin
            state_d  = ST_RELEASE;
            stage_d  = stage_q + 3'd1;
            cntClear = 1'b1;
          end else begin
            cntDec = 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d  = ST_HOLD;
          stage_d  = '0;
          rstVec_d = '1;
          cntClear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_HOLD;
      stage_q  <= '0;
      rstVec_q <= '1;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      rstVec_q <= rstVec_d;
    end
  end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign rst_o   = rstVec_q;
  assign stage_o = stage_q;
  assign busy_o  = (state_q != ST_DONE);
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: event-timed reference model plus directed scenarios.
// Honours RESET_SEQUENCER_TIMEOUT_EN the same way the design does.
module tb_reset_sequencer;

  localparam int NumOuts    = 3;
  localparam int HoldCycles = 16;
  localparam int StageGap   = 4;
  localparam int AckTimeout = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               swRstReq = 1'b0;
  logic [NumOuts-1:0] stageAck = '0;
  logic [NumOuts-1:0] rstOut;
  logic [2:0]         stageOut;
  logic               busy;
  logic               done;
  logic               timeout;

  int testsRun = 0;
  int testsFailed = 0;

  reset_sequencer #(
    .NUM_OUTS    (NumOuts),
    .HOLD_CYCLES (HoldCycles),
    .STAGE_GAP   (StageGap),
    .ACK_TIMEOUT (AckTimeout)
  ) dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .sw_rst_req_i (swRstReq),
    .stage_ack_i  (stageAck),
    .rst_o        (rstOut),
    .stage_o      (stageOut),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout)
  );

  always #10 clock = ~clock;

  // Reference model in terms of absolute edge numbers: when the next release is
  // due, how many stages are out, and whether an acknowledge is being awaited.
  int edgeNo = 0;
  bit modelValid = 1'b0;
  int relCnt = 0;
  bit waiting = 1'b0;
  int waitStart = 0;
  int nextRel = 0;
  bit mDone = 1'b0;
  bit mTimeout = 1'b0;

  task automatic restartModel(input int e);
    relCnt  = 0;
    waiting = 1'b0;
    mDone   = 1'b0;
    nextRel = e + HoldCycles + 1;
  endtask

  always @(posedge clock) begin
    edgeNo++;
    if (reset) begin
      modelValid = 1'b1;
      mTimeout   = 1'b0;
      restartModel(edgeNo);
    end else if (modelValid) begin
      if (swRstReq) begin
        restartModel(edgeNo);
      end else if (waiting) begin
        if (stageAck[relCnt-1]) begin
          waiting = 1'b0;
          if (relCnt == NumOuts) mDone = 1'b1;
          else nextRel = edgeNo + StageGap;
        end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
        else if (edgeNo - waitStart >= AckTimeout) begin
          mTimeout = 1'b1;
          restartModel(edgeNo);
        end
`endif
      end else if (!mDone && edgeNo == nextRel) begin
        relCnt++;
        waiting   = 1'b1;
        waitStart = edgeNo;
      end
    end
  end

  function automatic logic [NumOuts-1:0] expRst();
    logic [NumOuts-1:0] v;
    for (int k = 0; k < NumOuts; k++) v[k] = (k >= relCnt);
    return v;
  endfunction

  function automatic int expStage();
    if (relCnt == 0) return 0;
    if (waiting || mDone) return relCnt - 1;
    if (edgeNo >= nextRel - 1) return relCnt;
    return relCnt - 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNo, actual, expected);
    end
  endtask

  // Every settled cycle after the first reset edge is compared against the model.
  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("model rst_o", 32'(rstOut), 32'(expRst()));
      checkOutput("model stage_o", 32'(stageOut), 32'(expStage()));
      checkOutput("model busy_o", 32'(busy), 32'(!mDone));
      checkOutput("model done_o", 32'(done), 32'(mDone));
      checkOutput("model timeout_o", 32'(timeout), 32'(mTimeout));
    end
  end

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [NumOuts-1:0] ack, input logic sw);
    stageAck = ack;
    swRstReq = sw;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    waitEdges(3);
    reset = 1'b0;
  endtask

  initial begin
    // Power-up with acknowledges tied high.
    applyStimulus(3'b111, 1'b0);
    waitEdges(1);
    applyReset();
    checkOutput("powerup reset rst_o", 32'(rstOut), 32'b111);
    checkOutput("powerup reset busy_o", 32'(busy), 32'd1);
    waitEdges(16);
    checkOutput("powerup hold end rst_o", 32'(rstOut), 32'b111);
    waitEdges(1);
    checkOutput("powerup edge17 rst_o", 32'(rstOut), 32'b110);
    waitEdges(4);
    checkOutput("powerup edge21 rst_o", 32'(rstOut), 32'b110);
    waitEdges(1);
    checkOutput("powerup edge22 rst_o", 32'(rstOut), 32'b100);
    waitEdges(5);
    checkOutput("powerup edge27 rst_o", 32'(rstOut), 32'b000);
    checkOutput("powerup edge27 done_o", 32'(done), 32'd0);
    waitEdges(1);
    checkOutput("powerup done_o", 32'(done), 32'd1);
    checkOutput("powerup busy_o", 32'(busy), 32'd0);
    waitEdges(3);

    // Late acknowledge on stage 1; stage 2 ack already high and must be ignored early.
    applyStimulus(3'b101, 1'b0);
    applyReset();
    waitEdges(22);
    checkOutput("lateack edge22 rst_o", 32'(rstOut), 32'b100);
    waitEdges(10);
    checkOutput("lateack waiting rst_o", 32'(rstOut), 32'b100);
    checkOutput("lateack waiting stage_o", 32'(stageOut), 32'd1);
    applyStimulus(3'b111, 1'b0);
    waitEdges(4);
    checkOutput("lateack ack+3 rst_o", 32'(rstOut), 32'b100);
    waitEdges(1);
    checkOutput("lateack ack+4 rst_o", 32'(rstOut), 32'b000);
    waitEdges(2);
    checkOutput("lateack done_o", 32'(done), 32'd1);

    // Restart request while in the gap after stage 0.
    applyReset();
    waitEdges(19);
    checkOutput("restart pre rst_o", 32'(rstOut), 32'b110);
    applyStimulus(3'b111, 1'b1);
    waitEdges(1);
    applyStimulus(3'b111, 1'b0);
    checkOutput("restart rst_o", 32'(rstOut), 32'b111);
    checkOutput("restart stage_o", 32'(stageOut), 32'd0);
    waitEdges(16);
    checkOutput("restart hold end rst_o", 32'(rstOut), 32'b111);
    waitEdges(1);
    checkOutput("restart release rst_o", 32'(rstOut), 32'b110);
    waitEdges(12);

    // Restart and acknowledge in the same cycle, then reset during DONE.
    applyStimulus(3'b000, 1'b0);
    applyReset();
    waitEdges(17);
    checkOutput("simul pre rst_o", 32'(rstOut), 32'b110);
    applyStimulus(3'b001, 1'b1);
    waitEdges(1);
    checkOutput("simul restart rst_o", 32'(rstOut), 32'b111);
    checkOutput("simul restart stage_o", 32'(stageOut), 32'd0);
    applyStimulus(3'b111, 1'b0);
    waitEdges(17);
    checkOutput("simul release0 rst_o", 32'(rstOut), 32'b110);
    waitEdges(11);
    checkOutput("simul done_o", 32'(done), 32'd1);
    reset = 1'b1;
    waitEdges(1);
    checkOutput("done reset rst_o", 32'(rstOut), 32'b111);
    checkOutput("done reset done_o", 32'(done), 32'd0);
    checkOutput("done reset busy_o", 32'(busy), 32'd1);
    reset = 1'b0;
    waitEdges(2);

    // Stage 0 never acknowledged.
    applyStimulus(3'b000, 1'b0);
    applyReset();
    waitEdges(17);
    checkOutput("noack release rst_o", 32'(rstOut), 32'b110);
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    waitEdges(31);
    checkOutput("timeout pre rst_o", 32'(rstOut), 32'b110);
    checkOutput("timeout pre timeout_o", 32'(timeout), 32'd0);
    waitEdges(1);
    checkOutput("timeout rst_o", 32'(rstOut), 32'b111);
    checkOutput("timeout timeout_o", 32'(timeout), 32'd1);
    waitEdges(17);
    checkOutput("retry rst_o", 32'(rstOut), 32'b110);
    checkOutput("retry timeout_o", 32'(timeout), 32'd1);
`else
    waitEdges(60);
    checkOutput("noack stuck rst_o", 32'(rstOut), 32'b110);
    checkOutput("noack timeout_o", 32'(timeout), 32'd0);
    checkOutput("noack busy_o", 32'(busy), 32'd1);
`endif
    waitEdges(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
